// File: rtl/ray_pkg.sv
// +----------------------------------------------------------------------------+
// | ray_pkg : shared types and constants for the nearest-hit sphere scanner.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ray_pkg;

  localparam int T_W = 32;

  localparam logic [T_W-1:0] T_INF = 32'h7FFF_FFFF;
  localparam logic [7:0]     TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_GUARD = 3'd3,
    S_WAIT  = 3'd4,
    S_EVAL  = 3'd5,
    S_DONE  = 3'd6
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/hit_select.sv
// +----------------------------------------------------------------------------+
// | hit_select : picks the nearest non-negative intersection distance of one   |
// | sphere and compares it against the running best (signed 16.16).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hit_select
  import ray_pkg::*;
(
  input  logic [T_W-1:0] t0,
  input  logic [T_W-1:0] t1,
  input  logic           result,
  input  logic [T_W-1:0] best_t,
  output logic           valid,
  output logic [T_W-1:0] cand,
  output logic           better
);

  always_comb begin
    // Ray origin inside the sphere gives a negative near root; use the far one.
    cand   = t0[T_W-1] ? t1 : t0;
    valid  = result & ~cand[T_W-1];
    better = valid & ($signed(cand) < $signed(best_t));
  end

endmodule

`default_nettype wire

// File: rtl/nearest_hit_scan.sv
// +----------------------------------------------------------------------------+
// | nearest_hit_scan : sequences the sphere table through an intersection      |
// | engine and keeps the nearest hit. Option: NEAREST_SCAN_TIMEOUT_EN.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nearest_hit_scan
  import ray_pkg::*;
#(
  parameter int MAX_SPHERES = 16,
  parameter int IDX_W       = 4,
  parameter int ISECT_GUARD = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_start,
  input  logic [IDX_W:0]   num_spheres,
  output logic             busy,
  output logic [IDX_W-1:0] sph_addr,
  output logic             isect_start,
  input  logic             isect_finish,
  input  logic             isect_result,
  input  logic [T_W-1:0]   isect_t0,
  input  logic [T_W-1:0]   isect_t1,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [T_W-1:0]   hit_t,
  output logic             err
);

  localparam logic [IDX_W:0] MAX_N      = (IDX_W+1)'(MAX_SPHERES);
  localparam logic [7:0]     GUARD_LAST = 8'((ISECT_GUARD > 0) ? ISECT_GUARD - 1 : 0);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [7:0]       guard_q, guard_d;
  logic [T_W-1:0]   best_q, best_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [T_W-1:0]   hit_t_q, hit_t_d;
  logic             res_q, res_d;
  logic [T_W-1:0]   t0_q, t0_d;
  logic [T_W-1:0]   t1_q, t1_d;

  logic [IDX_W:0]   n_clamped;
  logic             last_sphere;
  logic             cand_valid;
  logic [T_W-1:0]   cand_t;
  logic             cand_better;

`ifdef NEAREST_SCAN_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
`endif

  hit_select u_hit_select (
    .t0     (t0_q),
    .t1     (t1_q),
    .result (res_q),
    .best_t (best_q),
    .valid  (cand_valid),
    .cand   (cand_t),
    .better (cand_better)
  );

  assign n_clamped   = (num_spheres > MAX_N) ? MAX_N : num_spheres;
  assign last_sphere = (({1'b0, idx_q} + (IDX_W+1)'(1)) == count_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    guard_d   = guard_q;
    best_d    = best_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    hit_t_d   = hit_t_q;
    res_d     = res_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
`ifdef NEAREST_SCAN_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          hit_d     = 1'b0;
          hit_idx_d = '0;
          hit_t_d   = '0;
          best_d    = T_INF;
          idx_d     = '0;
          count_d   = n_clamped;
`ifdef NEAREST_SCAN_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          state_d   = (n_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        guard_d = '0;
`ifdef NEAREST_SCAN_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = (ISECT_GUARD == 0) ? S_WAIT : S_GUARD;
      end
      S_GUARD: begin
        // isect_finish may still be high from the previous sphere here.
        if (guard_q == GUARD_LAST) state_d = S_WAIT;
        else                       guard_d = guard_q + 8'd1;
      end
      S_WAIT: begin
        if (isect_finish) begin
          res_d   = isect_result;
          t0_d    = isect_t0;
          t1_d    = isect_t1;
          state_d = S_EVAL;
        end
`ifdef NEAREST_SCAN_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LIMIT - 8'd1) begin
          res_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_EVAL;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      S_EVAL: begin
        if (cand_better) begin
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
          hit_t_d   = cand_t;
          best_d    = cand_t;
        end
        if (last_sphere) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      guard_q   <= '0;
      best_q    <= T_INF;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      hit_t_q   <= '0;
      res_q     <= 1'b0;
      t0_q      <= '0;
      t1_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      guard_q   <= guard_d;
      best_q    <= best_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      hit_t_q   <= hit_t_d;
      res_q     <= res_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
    end
  end

`ifdef NEAREST_SCAN_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // cand_valid is folded into cand_better; kept visible for debug.
  logic unused_ok;
  assign unused_ok = cand_valid;

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign isect_start = (state_q == S_ISSUE);
  assign sph_addr    = idx_q;
  assign hit         = hit_q;
  assign hit_idx     = hit_idx_q;
  assign hit_t       = hit_t_q;

endmodule

`default_nettype wire
